// File: rtl/ps2_key_decoder.sv
// rtl/ps2_key_decoder.sv - PS/2 keyboard frame receiver and scan-code event decoder
module ps2_key_decoder #(
    parameter int CLK_KHZ    = 49152,
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT_US = 200
) (
    input  logic        clk_49m,
    input  logic        reset,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [10:0] ps2_key,
    output logic        busy,
    output logic [7:0]  err_count
);
    localparam int TIMEOUT_CYC = CLK_KHZ * TIMEOUT_US / 1000;
    localparam int GAP_W       = $clog2(TIMEOUT_CYC + 1);
    localparam int FILT_W      = $clog2(FILTER_LEN + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    // Index 0 is ps2_clk, index 1 is ps2_data.
    logic [1:0]        sync1, sync2, filt;
    logic [FILT_W-1:0] stab_cnt [2];
    logic              filt_clk_q;
    logic              fe, sdata;

    state_t            state, state_n;
    logic [2:0]        bit_cnt;
    logic [7:0]        shreg;
    logic              par;
    logic [GAP_W-1:0]  gap_cnt;
    logic              frame_ok, frame_bad, timeout;
    logic              byte_valid;

    logic [2:0]        skip_cnt;
    logic              ext_flag, rel_flag;
    logic              ignored;

    always_ff @(posedge clk_49m or negedge reset) begin
        if (!reset) begin
            sync1      <= 2'b11;
            sync2      <= 2'b11;
            filt       <= 2'b11;
            filt_clk_q <= 1'b1;
            for (int i = 0; i < 2; i++) stab_cnt[i] <= '0;
        end else begin
            sync1      <= {ps2_data, ps2_clk};
            sync2      <= sync1;
            filt_clk_q <= filt[0];
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == filt[i]) begin
                    stab_cnt[i] <= '0;
                end else if (stab_cnt[i] == FILT_W'(FILTER_LEN - 1)) begin
                    filt[i]     <= sync2[i];
                    stab_cnt[i] <= '0;
                end else begin
                    stab_cnt[i] <= stab_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign fe    = filt_clk_q & ~filt[0];
    assign sdata = filt[1];
    assign busy  = (state != IDLE);

    always_comb begin
        state_n   = state;
        frame_ok  = 1'b0;
        frame_bad = 1'b0;
        timeout   = 1'b0;
        if (fe) begin
            case (state)
                IDLE:   if (!sdata) state_n = DATA;
                DATA:   if (bit_cnt == 3'd7) state_n = PARITY;
                PARITY: state_n = STOP;
                STOP: begin
                    state_n = IDLE;
                    if (sdata && (^{shreg, par})) frame_ok  = 1'b1;
                    else                          frame_bad = 1'b1;
                end
                default: state_n = IDLE;
            endcase
        end else if (busy && gap_cnt == GAP_W'(TIMEOUT_CYC - 1)) begin
            timeout = 1'b1;
            state_n = IDLE;
        end
    end

    always_ff @(posedge clk_49m or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            shreg      <= '0;
            par        <= 1'b0;
            gap_cnt    <= '0;
            byte_valid <= 1'b0;
        end else begin
            state      <= state_n;
            byte_valid <= frame_ok;
            gap_cnt    <= (fe || !busy) ? '0 : gap_cnt + 1'b1;
            if (fe) begin
                case (state)
                    IDLE:   bit_cnt <= '0;
                    DATA: begin
                        shreg   <= {sdata, shreg[7:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                    PARITY: par <= sdata;
                    default: ;
                endcase
            end
        end
    end

    // Keyboard ack/self-test/echo/resend bytes carry no key unless a prefix is pending.
    always_comb begin
        ignored = 1'b0;
        case (shreg)
            8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'h00, 8'hFF: ignored = !(ext_flag || rel_flag);
            default: ignored = 1'b0;
        endcase
    end

    always_ff @(posedge clk_49m or negedge reset) begin
        if (!reset) begin
            ps2_key   <= '0;
            err_count <= '0;
            skip_cnt  <= '0;
            ext_flag  <= 1'b0;
            rel_flag  <= 1'b0;
        end else begin
            if ((frame_bad || timeout) && err_count != 8'hFF)
                err_count <= err_count + 1'b1;
            if (frame_bad || timeout) begin
                ext_flag <= 1'b0;
                rel_flag <= 1'b0;
            end else if (byte_valid) begin
                if (skip_cnt != 3'd0) begin
                    skip_cnt <= skip_cnt - 1'b1;
                end else if (shreg == 8'hE1) begin
                    skip_cnt <= 3'd7;
                end else if (shreg == 8'hE0) begin
                    ext_flag <= 1'b1;
                end else if (shreg == 8'hF0) begin
                    rel_flag <= 1'b1;
                end else if (!ignored) begin
                    ps2_key  <= {~ps2_key[10], ~rel_flag, ext_flag, shreg};
                    ext_flag <= 1'b0;
                    rel_flag <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb/tb_ps2_key_decoder.sv - directed vector bench for ps2_key_decoder
module tb_ps2_key_decoder;
    localparam int H = 25;

    logic        clk_49m = 1'b0;
    logic        reset   = 1'b0;
    logic        ps2_clk = 1'b1;
    logic        ps2_data = 1'b1;
    logic [10:0] ps2_key;
    logic        busy;
    logic [7:0]  err_count;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [7:0]  code;
        bit          good;
        logic [10:0] key;
        logic [7:0]  err;
    } vec_t;

    vec_t vecs[26];

    ps2_key_decoder dut (
        .clk_49m  (clk_49m),
        .reset    (reset),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .ps2_key  (ps2_key),
        .busy     (busy),
        .err_count(err_count)
    );

    always #5 clk_49m = ~clk_49m;

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk_49m);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_bits(input logic [7:0] b, input bit good, input int nbits);
        logic [10:0] frame;
        frame = {1'b1, good ? ~^b : ^b, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_data = frame[i];
            wait_cyc(H);
            ps2_clk = 1'b0;
            wait_cyc(H);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
    endtask

    initial begin
        vecs[0]  = '{8'h16, 1'b1, 11'h616, 8'd0};
        vecs[1]  = '{8'hF0, 1'b1, 11'h616, 8'd0};
        vecs[2]  = '{8'h16, 1'b1, 11'h016, 8'd0};
        vecs[3]  = '{8'hE0, 1'b1, 11'h016, 8'd0};
        vecs[4]  = '{8'h75, 1'b1, 11'h775, 8'd0};
        vecs[5]  = '{8'hE0, 1'b1, 11'h775, 8'd0};
        vecs[6]  = '{8'hF0, 1'b1, 11'h775, 8'd0};
        vecs[7]  = '{8'h75, 1'b1, 11'h175, 8'd0};
        vecs[8]  = '{8'h1E, 1'b0, 11'h175, 8'd1};
        vecs[9]  = '{8'h1E, 1'b1, 11'h61E, 8'd1};
        vecs[10] = '{8'hFA, 1'b1, 11'h61E, 8'd1};
        vecs[11] = '{8'hE1, 1'b1, 11'h61E, 8'd1};
        vecs[12] = '{8'h14, 1'b1, 11'h61E, 8'd1};
        vecs[13] = '{8'h77, 1'b1, 11'h61E, 8'd1};
        vecs[14] = '{8'hE1, 1'b1, 11'h61E, 8'd1};
        vecs[15] = '{8'hF0, 1'b1, 11'h61E, 8'd1};
        vecs[16] = '{8'h14, 1'b1, 11'h61E, 8'd1};
        vecs[17] = '{8'hF0, 1'b1, 11'h61E, 8'd1};
        vecs[18] = '{8'h77, 1'b1, 11'h61E, 8'd1};
        vecs[19] = '{8'h46, 1'b1, 11'h246, 8'd1};
        vecs[20] = '{8'hF0, 1'b1, 11'h246, 8'd1};
        vecs[21] = '{8'h00, 1'b1, 11'h400, 8'd1};
        vecs[22] = '{8'hFF, 1'b1, 11'h400, 8'd1};
        vecs[23] = '{8'hE0, 1'b1, 11'h400, 8'd1};
        vecs[24] = '{8'h1C, 1'b0, 11'h400, 8'd2};
        vecs[25] = '{8'h1C, 1'b1, 11'h21C, 8'd2};

        wait_cyc(5);
        check("reset_key", 32'(ps2_key), 32'h0);
        check("reset_err", 32'(err_count), 32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        reset = 1'b1;
        wait_cyc(20);

        for (int i = 0; i < 26; i++) begin
            send_bits(vecs[i].code, vecs[i].good, 11);
            wait_cyc(40);
            check($sformatf("vec%0d_key", i), 32'(ps2_key), 32'(vecs[i].key));
            check($sformatf("vec%0d_err", i), 32'(err_count), 32'(vecs[i].err));
            check($sformatf("vec%0d_busy", i), 32'(busy), 32'h0);
        end

        // Partial frame abandoned: start bit plus four data bits.
        send_bits(8'h2E, 1'b1, 5);
        wait_cyc(5);
        check("to_busy_mid", 32'(busy), 32'h1);
        wait_cyc(9000);
        check("to_busy_before", 32'(busy), 32'h1);
        wait_cyc(1000);
        check("to_busy_after", 32'(busy), 32'h0);
        check("to_err", 32'(err_count), 32'd3);
        send_bits(8'h2E, 1'b1, 11);
        wait_cyc(40);
        check("to_2e_key", 32'(ps2_key), 32'h62E);
        check("to_2e_err", 32'(err_count), 32'd3);

        // Short clock glitches with data held low must not start a frame.
        ps2_data = 1'b0;
        wait_cyc(30);
        for (int g = 0; g < 4; g++) begin
            ps2_clk = 1'b0;
            wait_cyc(5);
            ps2_clk = 1'b1;
            wait_cyc(20);
        end
        wait_cyc(20);
        check("glitch_busy", 32'(busy), 32'h0);
        check("glitch_key", 32'(ps2_key), 32'h62E);
        ps2_data = 1'b1;
        wait_cyc(30);

        // Reset in the middle of a frame.
        send_bits(8'h16, 1'b1, 4);
        wait_cyc(5);
        check("mid_busy", 32'(busy), 32'h1);
        reset = 1'b0;
        wait_cyc(3);
        check("mid_rst_key", 32'(ps2_key), 32'h0);
        check("mid_rst_err", 32'(err_count), 32'h0);
        check("mid_rst_busy", 32'(busy), 32'h0);
        reset = 1'b1;
        wait_cyc(20);
        send_bits(8'h16, 1'b1, 11);
        wait_cyc(40);
        check("post_rst_key", 32'(ps2_key), 32'h616);
        check("post_rst_err", 32'(err_count), 32'h0);
        check("post_rst_busy", 32'(busy), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
